// File: rtl/acc_bank.sv
// Multi-lane, multi-slot interleaved accumulator bank with flush drain.
// Define ACC_BANK_SAT_EN for saturating adds with per-lane sticky flags.
module acc_bank #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_ACC = 32,
    parameter int LANES     = 4,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH_IN-1:0]    in_data,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [$clog2(DEPTH)-1:0]     depth_sel,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WIDTH_ACC-1:0]   out_data,
    output logic [$clog2(DEPTH)-1:0]     out_slot,
    output logic [LANES-1:0]             out_sat
);

    localparam int SW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] r_fidx;
    logic [SW-1:0] r_fdepth;
    logic [SW-1:0] w_dsel;

    logic signed [WIDTH_ACC-1:0] r_acc [DEPTH][LANES];
    logic signed [WIDTH_ACC-1:0] w_x   [LANES];
    logic signed [WIDTH_ACC-1:0] w_sum [LANES];

    logic                       r_out_valid;
    logic [LANES*WIDTH_ACC-1:0] r_out_data;
    logic [SW-1:0]              r_out_slot;

    logic w_out_free;
    logic w_beat;
    logic w_emit;
    logic w_flush_go;
    logic w_capture;

    // Clip the requested depth so a non-power-of-two DEPTH never indexes past the bank.
    assign w_dsel = (int'(depth_sel) > DEPTH - 1) ? SW'(DEPTH - 1) : depth_sel;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == RUN) && w_out_free && !reset;
    assign w_beat     = in_valid && in_ready;
    assign w_capture  = w_beat && in_last;
    assign w_emit     = (r_state == FLUSH) && w_out_free;
    assign w_flush_go = (r_state == RUN) && flush;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_slot  = r_out_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (flush) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_out_free && (r_fidx == r_fdepth)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

`ifdef ACC_BANK_SAT_EN
    localparam logic signed [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic signed [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

    logic signed [WIDTH_ACC:0] w_wide [LANES];
    logic [LANES-1:0]          w_ovf;
    logic [LANES-1:0]          w_nflag;
    logic [LANES-1:0]          r_flag [DEPTH];
    logic [LANES-1:0]          r_out_sat;

    always_comb begin
        w_ovf   = '0;
        w_nflag = '0;
        for (int l = 0; l < LANES; l++) begin
            w_x[l]    = WIDTH_ACC'($signed(in_data[l*WIDTH_IN +: WIDTH_IN]));
            w_wide[l] = (WIDTH_ACC+1)'(r_acc[r_ptr][l]) + (WIDTH_ACC+1)'(w_x[l]);
            if (in_first) begin
                w_sum[l] = w_x[l];
            end else if (w_wide[l][WIDTH_ACC] != w_wide[l][WIDTH_ACC-1]) begin
                w_sum[l] = w_wide[l][WIDTH_ACC] ? ACC_MIN : ACC_MAX;
                w_ovf[l] = 1'b1;
            end else begin
                w_sum[l] = w_wide[l][WIDTH_ACC-1:0];
            end
            w_nflag[l] = in_first ? w_ovf[l] : (r_flag[r_ptr][l] | w_ovf[l]);
        end
    end

    // Sticky overflow flags travel with the slot and reset on load or emission.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_flag[d] <= '0;
            end
            r_out_sat <= '0;
        end else begin
            if (w_beat) begin
                r_flag[r_ptr] <= in_last ? '0 : w_nflag;
                if (in_last) begin
                    r_out_sat <= w_nflag;
                end
            end
            if (w_emit) begin
                r_out_sat      <= r_flag[r_fidx];
                r_flag[r_fidx] <= '0;
            end
        end
    end

    assign out_sat = r_out_sat;
`else
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_x[l] = WIDTH_ACC'($signed(in_data[l*WIDTH_IN +: WIDTH_IN]));
            if (in_first) begin
                w_sum[l] = w_x[l];
            end else begin
                w_sum[l] = r_acc[r_ptr][l] + w_x[l];
            end
        end
    end

    assign out_sat = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_acc[d][l] <= '0;
                end
            end
            r_ptr       <= '0;
            r_fidx      <= '0;
            r_fdepth    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_slot  <= '0;
        end else begin
            if (w_beat) begin
                r_ptr <= (r_ptr >= w_dsel) ? '0 : r_ptr + 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    r_acc[r_ptr][l] <= in_last ? '0 : w_sum[l];
                end
                if (in_last) begin
                    for (int l = 0; l < LANES; l++) begin
                        r_out_data[l*WIDTH_ACC +: WIDTH_ACC] <= w_sum[l];
                    end
                    r_out_slot <= r_ptr;
                end
            end
            // Any coincident beat is already folded in above; the drain restarts at slot 0.
            if (w_flush_go) begin
                r_ptr    <= '0;
                r_fidx   <= '0;
                r_fdepth <= w_dsel;
            end
            if (w_emit) begin
                for (int l = 0; l < LANES; l++) begin
                    r_out_data[l*WIDTH_ACC +: WIDTH_ACC] <= r_acc[r_fidx][l];
                    r_acc[r_fidx][l] <= '0;
                end
                r_out_slot <= r_fidx;
                r_fidx     <= r_fidx + 1'b1;
            end
            r_out_valid <= w_capture || w_emit || (r_out_valid && !out_ready);
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Randomized bench for acc_bank with a slot-array reference model and
// expected-output queue; directed cases cover single-slot, interleave, backpressure, flush, saturation, reset.
module tb_acc_bank;

    localparam int WI = 16;
    localparam int WA = 16;
    localparam int NL = 4;
    localparam int ND = 4;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [1:0]    depth_sel = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic [1:0]    out_slot;
    logic [3:0]    out_sat;

    acc_bank #(
        .WIDTH_IN (WI),
        .WIDTH_ACC(WA),
        .LANES    (NL),
        .DEPTH    (ND)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_first (in_first),
        .in_last  (in_last),
        .depth_sel(depth_sel),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_slot (out_slot),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic [1:0]  slot;
        logic [3:0]  s;
        logic [63:0] d;
    } exp_t;

    int     n_chk = 0;
    int     n_pass = 0;
    int     n_hs = 0;
    longint m_acc [ND][NL];
    bit     m_sat [ND][NL];
    int     m_ptr;
    bit     m_run;
    int     m_fcnt;
    exp_t   q[$];

    bit     run0;
    bit     exp_rdy;
    bit     pop;
    int     qs;
    exp_t   e;
    exp_t   ne;
    longint v;
    longint x;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapa(input longint a);
        longint r;
        r = a & 64'hFFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    function automatic longint lane_in(input int l);
        return longint'($signed(in_data[l*16 +: 16]));
    endfunction

    function automatic longint lane_out(input int l);
        return longint'($signed(out_data[l*16 +: 16]));
    endfunction

    function automatic longint lane_exp(input logic [63:0] d, input int l);
        return longint'($signed(d[l*16 +: 16]));
    endfunction

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < ND; s++) begin
            for (int l = 0; l < NL; l++) begin
                m_acc[s][l] = 0;
                m_sat[s][l] = 0;
            end
        end
        q.delete();
        m_ptr  = 0;
        m_run  = 1;
        m_fcnt = 0;
    endfunction

    function automatic exp_t take_slot(input int s, input bit fl);
        exp_t t;
        t.fl   = fl;
        t.slot = 2'(s);
        for (int l = 0; l < NL; l++) begin
            t.d[l*16 +: 16] = m_acc[s][l][15:0];
            t.s[l]          = m_sat[s][l];
            m_acc[s][l]     = 0;
            m_sat[s][l]     = 0;
        end
        return t;
    endfunction

    // Reference model: evaluates what the coming rising edge will do.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_in_ready", longint'(in_ready), 0);
            m_reset();
        end else begin
            run0    = m_run;
            qs      = q.size();
            pop     = 0;
            exp_rdy = run0 && (qs == 0 || out_ready);
            check("in_ready", longint'(in_ready), longint'(exp_rdy));
            if (run0) check("out_valid", longint'(out_valid), longint'(qs != 0));
            if (out_valid) begin
                if (qs == 0) begin
                    check("spurious_out", longint'(out_valid), 0);
                end else begin
                    e = q[0];
                    check("out_slot", longint'(out_slot), longint'(e.slot));
                    for (int l = 0; l < NL; l++) begin
                        check($sformatf("out_lane%0d", l), lane_out(l), lane_exp(e.d, l));
                        check($sformatf("out_sat%0d", l), longint'(out_sat[l]), longint'(e.s[l]));
                    end
                    if (out_ready) pop = 1;
                end
            end
            if (in_valid && exp_rdy) begin
                for (int l = 0; l < NL; l++) begin
                    x = lane_in(l);
                    if (in_first) begin
                        m_acc[m_ptr][l] = x;
                        m_sat[m_ptr][l] = 0;
                    end else begin
                        v = m_acc[m_ptr][l] + x;
`ifdef ACC_BANK_SAT_EN
                        if (v > MAXV) begin
                            v = MAXV;
                            m_sat[m_ptr][l] = 1;
                        end else if (v < MINV) begin
                            v = MINV;
                            m_sat[m_ptr][l] = 1;
                        end
`else
                        v = wrapa(v);
`endif
                        m_acc[m_ptr][l] = v;
                    end
                end
                if (in_last) begin
                    ne = take_slot(m_ptr, 0);
                    q.push_back(ne);
                end
                m_ptr = (m_ptr == int'(depth_sel)) ? 0 : m_ptr + 1;
            end
            if (run0 && flush) begin
                for (int s = 0; s <= int'(depth_sel); s++) begin
                    ne = take_slot(s, 1);
                    q.push_back(ne);
                end
                m_ptr  = 0;
                m_fcnt = int'(depth_sel) + 1;
                m_run  = 0;
            end
            if (pop) begin
                e = q.pop_front();
                n_hs++;
                if (e.fl) begin
                    m_fcnt--;
                    if (m_fcnt == 0) m_run = 1;
                end
            end
        end
    end

    task automatic send(input bit f, input bit l, input logic [63:0] d);
        int n;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_wait();
        int n;
        n = 0;
        while (!(m_run && q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!(m_run && q.size() == 0)) check("idle_timeout", longint'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic zero_slots(input string tag);
        for (int s = 0; s < ND; s++) begin
            send(0, 1, '0);
            @(negedge clk);
            check(tag, lane_out(0), 0);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] rand_lane();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 200) - 100);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_slot", longint'(out_slot), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_ready_after", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single slot: 5 - 3 + 10
        depth_sel = 2'd0;
        send(1, 0, pk(5, 1, 2, 3));
        send(0, 0, pk(-3, 4, 5, 6));
        send(0, 1, pk(10, 7, 8, 9));
        @(negedge clk);
        check("single_valid", longint'(out_valid), 1);
        check("single_lane0", lane_out(0), 12);
        check("single_slot", longint'(out_slot), 0);
        idle_wait();

        // Interleave two slots
        depth_sel = 2'd1;
        send(1, 0, pk(1, 0, 0, 0));
        send(1, 0, pk(100, 0, 0, 0));
        send(0, 1, pk(2, 0, 0, 0));
        @(negedge clk);
        check("ilv_lane0_s0", lane_out(0), 3);
        check("ilv_slot0", longint'(out_slot), 0);
        @(posedge clk);
        #1;
        send(0, 1, pk(200, 0, 0, 0));
        @(negedge clk);
        check("ilv_lane0_s1", lane_out(0), 300);
        check("ilv_slot1", longint'(out_slot), 1);
        idle_wait();

        // Backpressure
        depth_sel = 2'd0;
        out_ready = 1'b0;
        send(1, 1, pk(7, -7, 70, -70));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", longint'(in_ready), 0);
            check("bp_hold", lane_out(0), 7);
        end
        hs0 = n_hs;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_one_hs", longint'(n_hs - hs0), 1);
        idle_wait();

        // Flush four slots
        depth_sel = 2'd3;
        for (int s = 0; s < 4; s++) send(1, 0, pk(s + 1, 10 * s, -s, 3));
        hs0 = n_hs;
        pulse_flush();
        n = 0;
        while (!m_run && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("flush_hs", longint'(n_hs - hs0), 4);
        idle_wait();
        zero_slots("flush_zero");
        idle_wait();

        // Saturation / wrap on lane 0
        depth_sel = 2'd0;
        send(1, 0, pk(30000, -30000, 1, 0));
        send(0, 1, pk(30000, -30000, 1, 0));
        @(negedge clk);
`ifdef ACC_BANK_SAT_EN
        check("sat_lane0", lane_out(0), 32767);
        check("sat_flag0", longint'(out_sat[0]), 1);
        check("sat_lane1", lane_out(1), -32768);
`else
        check("sat_lane0", lane_out(0), -5536);
        check("sat_flag0", longint'(out_sat[0]), 0);
        check("sat_lane1", lane_out(1), 5536);
`endif
        check("sat_lane2", lane_out(2), 2);
        idle_wait();

        // Reset in the middle of a flush
        depth_sel = 2'd3;
        for (int s = 0; s < 4; s++) send(1, 0, pk(11 + s, 5, 5, 5));
        hs0 = n_hs;
        pulse_flush();
        n = 0;
        while (n_hs - hs0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rstfl_two_hs", longint'(n_hs - hs0), 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstfl_valid", longint'(out_valid), 0);
        check("rstfl_ready", longint'(in_ready), 1);
        hs0 = n_hs;
        repeat (4) @(negedge clk);
        check("rstfl_no_out", longint'(n_hs - hs0), 0);
        @(posedge clk);
        #1;
        zero_slots("rstfl_zero");
        idle_wait();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_first  = ($urandom_range(0, 9) < 3);
            in_last   = ($urandom_range(0, 9) < 3);
            for (int l = 0; l < NL; l++) in_data[l*16 +: 16] = rand_lane();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if (m_ptr == 0 && $urandom_range(0, 7) == 0) depth_sel = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle_wait();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 16, meaning the signed width of each input lane.
REQ-002 SHALL have parameter WIDTH_ACC, default 32, meaning the signed width of each accumulator; WIDTH_ACC >= WIDTH_IN.
REQ-003 SHALL have parameter LANES, default 4, meaning the number of independent parallel channels.
REQ-004 SHALL have parameter DEPTH, default 4, meaning the number of interleaved partial-sum slots per lane; DEPTH >= 2.
REQ-005 SHALL have ports as follows; reset is synchronous and active-high, and clock is clk:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat
- in_data  in  LANES*WIDTH_IN  signed lane samples, lane 0 in the LSBs
- in_first  in  1  beat starts a new sum in the current slot
- in_last  in  1  beat completes the sum in the current slot
- depth_sel  in  clog2(DEPTH)  number of active slots minus 1
- flush  in  1  single-cycle request to drain all active slots
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  LANES*WIDTH_ACC  lane sums
- out_slot  out  clog2(DEPTH)  slot index of the result
- out_sat  out  LANES  per-lane saturation flag

Function
REQ-006 SHALL form a beat on each cycle where in_valid=1 and in_ready=1.
REQ-007 SHALL keep a slot pointer that starts at 0, advances by one per beat, and wraps to 0 after the value depth_sel.
REQ-008 SHALL, on a beat with in_first=1, load acc[slot] with sign-extended in_data; otherwise it SHALL add sign-extended in_data to acc[slot], per lane.
REQ-009 SHALL, on a beat with in_last=1, capture the updated slot value into the output register and assert out_valid on the next cycle, so latency is 1 cycle; the slot is then cleared to 0.
REQ-010 SHALL treat a beat with both in_first=1 and in_last=1 as a single-beat sum, giving out_data = the input.
REQ-011 SHALL drive in_ready = (state==RUN) and (out_valid=0 or out_ready=1).
REQ-012 SHALL hold out_data, out_slot and out_sat stable while out_valid=1 and out_ready=0.
REQ-013 SHALL implement the FSM RUN -> FLUSH when flush=1 is sampled in RUN; flush is ignored in FLUSH.
REQ-014 SHALL, in FLUSH, deassert in_ready and emit slots 0..depth_sel in order, one per output handshake, clearing each emitted slot.
REQ-015 SHALL return to RUN after the handshake of slot depth_sel, with the slot pointer reset to 0.
REQ-016 SHALL, when flush and an accepted beat coincide, process the beat first, so the flushed values include it.
REQ-017 SHALL sample depth_sel only in RUN; a change mid-sum is legal, with the pointer wrapping at the new value; slots above it are retained but not flushed.

Reset
REQ-018 SHALL, on reset, clear all accumulators, the slot pointer, out_data, out_slot, out_sat and out_valid to 0, and enter RUN.
REQ-019 SHALL let reset asserted mid-FLUSH or mid-sum abort the operation with no output emitted; in_ready SHALL be 0 during reset.

Configuration
REQ-020 SHALL, when macro ACC_BANK_SAT_EN is defined, clamp each lane add to [-2^(WIDTH_ACC-1), 2^(WIDTH_ACC-1)-1] and set a per-lane slot flag, cleared by in_first or emission and reported on out_sat with the result.
REQ-021 SHALL, without ACC_BANK_SAT_EN, wrap modulo 2^WIDTH_ACC and tie out_sat to 0.

Verification
REQ-022 SHALL cover the single-slot case: depth_sel=0, lane0 beats 5,-3,10 (first..last) -> out_data lane0=12, out_slot=0, one cycle after the last beat.
REQ-023 SHALL cover interleaving: depth_sel=1, beats alternating slots 0/1 with values 1,100,2,200 (last on beats 3,4) -> outputs 3 (slot 0) then 300 (slot 1).
REQ-024 SHALL cover backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and out_data held; releasing out_ready produces exactly one handshake.
REQ-025 SHALL cover flush: depth_sel=3 with slots holding 1,2,3,4 and flush pulsed -> four outputs in order slots 0..3, then RUN with all slots at 0.
REQ-026 SHALL cover saturation: with ACC_BANK_SAT_EN, WIDTH_ACC=16, adding 30000+30000 -> 32767 with out_sat[0]=1; without the macro -> -5536 with out_sat=0.
REQ-027 SHALL cover reset mid-FLUSH after 2 emissions -> out_valid=0 and accumulators 0 the next cycle, with no further outputs.
